// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_stream_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } reader_state_t;

   localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Command, RAM read port and output stream of the reader, bundled.
// RAM_STREAM_READER_LAST_EN adds data_out_last to the stream.
interface ram_stream_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   length;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_dout;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_out_valid;
   logic                  data_out_ready;
`ifdef RAM_STREAM_READER_LAST_EN
   logic                  data_out_last;

   modport master (
      input  start, base_addr, length, rd_dout, data_out_ready,
      output busy, done, rd_addr, data_out, data_out_valid, data_out_last
   );
   modport slave (
      output start, base_addr, length, rd_dout, data_out_ready,
      input  busy, done, rd_addr, data_out, data_out_valid, data_out_last
   );
`else
   modport master (
      input  start, base_addr, length, rd_dout, data_out_ready,
      output busy, done, rd_addr, data_out, data_out_valid
   );
   modport slave (
      output start, base_addr, length, rd_dout, data_out_ready,
      input  busy, done, rd_addr, data_out, data_out_valid
   );
`endif
endinterface

// File: rtl/ram_read_skid_buffer.sv
// Two-entry FIFO absorbing RAM read data while the stream is stalled.
// Entry 0 is always the oldest word and drives data_out directly.
module ram_read_skid_buffer
   import ram_stream_reader_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       count
);
   logic [SKID_DEPTH-1:0][WIDTH-1:0] ent_q, ent_d;
   logic [1:0] count_q, count_d, kept;
   logic       pop_ok, push_ok;

   always_comb begin
      ent_d   = ent_q;
      pop_ok  = pop && (count_q != 2'd0);
      kept    = count_q - {1'b0, pop_ok};
      push_ok = push && (kept != 2'(SKID_DEPTH));
      if (pop_ok) ent_d[0] = ent_q[1];
      // new word lands behind whatever survives the pop
      if (push_ok) begin
         if (kept == 2'd0) ent_d[0] = data_in;
         else              ent_d[1] = data_in;
      end
      count_d = kept + {1'b0, push_ok};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent_q   <= '0;
         count_q <= 2'd0;
      end else begin
         ent_q   <= ent_d;
         count_q <= count_d;
      end
   end

   assign data_out = ent_q[0];
   assign count    = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a wrapping RAM address range and streams the words out bubble-free.
// RAM_STREAM_READER_LAST_EN adds data_out_last on the final beat of a command.
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int SIZE       = 512
) (
   input logic                 clk,
   input logic                 rst_n,
   ram_stream_reader_if.master bus
);
`ifdef RAM_STREAM_READER_LAST_EN
   localparam int SKID_W = DATA_WIDTH + 1;
`else
   localparam int SKID_W = DATA_WIDTH;
`endif
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(SIZE - 1);
   localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH+1)'(1);

   reader_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic                  inflight_q, inflight_d;
   logic                  done_q, done_d;
   logic [1:0]            count;
   logic [2:0]            occ;
   logic                  pop, issue, cmd_go, cmd_zero;
   logic [SKID_W-1:0]     skid_in, skid_out;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      pop      = (count != 2'd0) && bus.data_out_ready;
      // words owned next cycle if we issue now must fit in the skid
      occ      = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
      issue    = (state_q == RUN) && (rem_q != '0) && (occ < 3'd2);
      cmd_go   = (state_q == IDLE) && bus.start && (bus.length != '0);
      cmd_zero = (state_q == IDLE) && bus.start && (bus.length == '0);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_go) state_d = RUN;
         RUN:     if (issue && rem_q == REM_ONE) state_d = DRAIN;
         DRAIN:   if (!inflight_q && count == 2'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q != IDLE);
   end

   always_comb begin
      rd_addr_d  = rd_addr_q;
      rem_d      = rem_q;
      inflight_d = issue;
      // last word leaves the skid this cycle, so done lines up with busy dropping next
      done_d     = cmd_zero ||
                   ((state_q == DRAIN) && !inflight_q && count == 2'd1 && pop);
      if (cmd_go) begin
         rd_addr_d = bus.base_addr;
         rem_d     = bus.length;
      end
      if (issue) begin
         rd_addr_d = (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + ADDR_WIDTH'(1);
         rem_d     = rem_q - REM_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_addr_q  <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rd_addr_q  <= rd_addr_d;
         rem_q      <= rem_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
      end
   end

`ifdef RAM_STREAM_READER_LAST_EN
   logic last_q, last_d;

   always_comb last_d = issue && (rem_q == REM_ONE);

   always_ff @(posedge clk) begin
      if (!rst_n) last_q <= 1'b0;
      else        last_q <= last_d;
   end

   assign skid_in           = {last_q, bus.rd_dout};
   assign bus.data_out_last = skid_out[DATA_WIDTH] && (count != 2'd0);
`else
   assign skid_in = bus.rd_dout;
`endif

   ram_read_skid_buffer #(.WIDTH(SKID_W)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (inflight_q),
      .data_in  (skid_in),
      .pop      (pop),
      .data_out (skid_out),
      .count    (count)
   );

   assign bus.rd_addr        = rd_addr_q;
   assign bus.done           = done_q;
   assign bus.data_out       = skid_out[DATA_WIDTH-1:0];
   assign bus.data_out_valid = (count != 2'd0);

endmodule
